handshake_word_sender: RTL

Upstream driver for the bit-serial peripheral receiver. Accepts a parallel word from the local controller and transmits it LSB-first, one bit per four-phase `send`/`ack` handshake. `data` is held stable for the whole handshake. A per-phase ack timeout aborts a transfer if the peripheral stalls. The block sits between the controller and the peripheral's `send`/`data`/`ack` pins, in the same clock domain.

---
 rtl/handshake_word_sender_if.sv | 14 +
 rtl/handshake_word_sender.sv | 102 ++++++++++
 2 files changed

// File: rtl/handshake_word_sender_if.sv
// handshake_word_sender_if: controller word request/status plus peripheral send/data/ack pins.
// master is the sender's view; slave is the controller/peripheral side.
interface handshake_word_sender_if #(parameter int WIDTH = 8);
    logic             start;
    logic [WIDTH-1:0] din;
    logic             busy;
    logic             done;
    logic             err;
    logic             send;
    logic             data;
    logic             ack;
    modport master (input start, din, ack, output busy, done, err, send, data);
    modport slave  (output start, din, ack, input busy, done, err, send, data);
endinterface

// File: rtl/handshake_word_sender.sv
// handshake_word_sender: sends a parallel word LSB-first, one bit per four-phase send/ack
// handshake, aborting with err if either phase waits TIMEOUT edges.
module handshake_word_sender #(
    parameter int WIDTH   = 8,
    parameter int TIMEOUT = 16
) (
    input logic clk,
    input logic rst,
    handshake_word_sender_if.master bus
);
    localparam int BW = WIDTH > 1 ? $clog2(WIDTH) : 1;
    localparam int WW = $clog2(TIMEOUT);
    localparam logic [BW-1:0] LAST = BW'(WIDTH - 1);
    localparam logic [WW-1:0] WMAX = WW'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, REQ, REL} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] sh_q, sh_d;
    logic [BW-1:0]    bcnt_q, bcnt_d;
    logic [WW-1:0]    wcnt_q, wcnt_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
    logic             send_q, send_d;
    logic             exit_ok;

    // REQ leaves on ack high, REL on ack low; exit beats timeout on the same edge
    assign exit_ok = state_q == REQ ? bus.ack : !bus.ack;

    always_comb begin
        state_d = state_q;
        sh_d    = sh_q;
        bcnt_d  = bcnt_q;
        wcnt_d  = wcnt_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        send_d  = send_q;
        if (state_q == IDLE) begin
            if (bus.start) begin
                state_d = REQ;
                sh_d    = bus.din;
                bcnt_d  = '0;
                wcnt_d  = '0;
                busy_d  = 1'b1;
                send_d  = 1'b1;
            end
        end else if (exit_ok) begin
            wcnt_d = '0;
            if (state_q == REQ) begin
                state_d = REL;
                send_d  = 1'b0;
            end else if (bcnt_q == LAST) begin
                state_d = IDLE;
                busy_d  = 1'b0;
                done_d  = 1'b1;
            end else begin
                state_d = REQ;
                sh_d    = sh_q >> 1;
                bcnt_d  = bcnt_q + 1'b1;
                send_d  = 1'b1;
            end
        end else if (wcnt_q == WMAX) begin
            state_d = IDLE;
            send_d  = 1'b0;
            busy_d  = 1'b0;
            err_d   = 1'b1;
        end else begin
            wcnt_d = wcnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            sh_q    <= '0;
            bcnt_q  <= '0;
            wcnt_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            send_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sh_q    <= sh_d;
            bcnt_q  <= bcnt_d;
            wcnt_q  <= wcnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
            send_q  <= send_d;
        end
    end

    // the shift register's LSB is the data flop, so data only moves when send rises
    assign bus.data = sh_q[0];
    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.err  = err_q;
    assign bus.send = send_q;
endmodule
